// File: rtl/cmd_scheduler.sv
// Round-robin command scheduler: NREQ requesters share one hash engine.
// Optional watchdog abort is compiled in with `define CMD_SCHEDULER_TIMEOUT_EN.
module cmd_scheduler #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                    Clk,
    input  logic                    Rst_n,
    input  logic [NREQ-1:0]         Req_i,
    input  logic                    Enable_i,
    output logic                    Eng_Start_o,
    output logic [$clog2(NREQ)-1:0] Eng_Sel_o,
    input  logic                    Eng_Done_i,
    output logic [NREQ-1:0]         Pending_o,
    output logic                    Busy_o,
    output logic [NREQ-1:0]         Done_o,
    output logic [NREQ-1:0]         Timeout_o
);
    localparam int SEL_W = $clog2(NREQ);
    localparam int SUM_W = SEL_W + 1;
    localparam logic [SUM_W-1:0] NREQ_S   = SUM_W'(NREQ);
    localparam logic [SEL_W-1:0] LAST_RST = SEL_W'(NREQ - 1);

    generate
        if (NREQ < 2 || NREQ > 16) begin : g_bad_nreq
            $error("cmd_scheduler: NREQ must be in 2..16");
        end
        if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
            $error("cmd_scheduler: TIMEOUT must be in 2..65535");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [NREQ-1:0]   pending_reg, pending_next;
    logic [SEL_W-1:0]  sel_reg, last_grant_reg;
    logic [NREQ-1:0]   done_reg, done_next;
    logic              grant_now, job_ending, fire_done, fire_tmo;
    logic [SUM_W-1:0]  rot_off, rot_sum;
    logic [NREQ-1:0]   rot_pend, first_hot, grant_hot;
    logic [SEL_W-1:0]  idx_chain [NREQ+1];
    logic [SEL_W-1:0]  grant_idx;

    genvar gi;

    // Rotate pending so the requester after last_grant sits at bit 0,
    // isolate the lowest set bit, then rotate the index back.
    assign rot_off   = {1'b0, last_grant_reg} + SUM_W'(1);
    assign rot_pend  = NREQ'({pending_reg, pending_reg} >> rot_off);
    assign first_hot = rot_pend & (~rot_pend + NREQ'(1));

    assign idx_chain[0] = '0;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_idx
            assign idx_chain[gi+1] = idx_chain[gi] | (first_hot[gi] ? SEL_W'(gi) : '0);
        end
    endgenerate

    assign rot_sum   = rot_off + {1'b0, idx_chain[NREQ]};
    assign grant_idx = SEL_W'((rot_sum >= NREQ_S) ? (rot_sum - NREQ_S) : rot_sum);

    assign grant_now = (state_reg == ST_IDLE) && Enable_i && (|pending_reg);
    assign grant_hot = grant_now ? (NREQ'(1) << grant_idx) : '0;

    // A new pulse on the granted requester's line wins over the grant clear.
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_pend
            assign pending_next[gi] = Req_i[gi] | (pending_reg[gi] & ~grant_hot[gi]);
        end
    endgenerate

    // The job stays in WAIT through the cycle its Done/Timeout pulse is visible.
    assign job_ending = (|done_reg) | (|Timeout_o);
    assign fire_done  = (state_reg == ST_WAIT) && !job_ending && Eng_Done_i;
    assign done_next  = fire_done ? (NREQ'(1) << sel_reg) : '0;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (grant_now)  state_next = ST_START;
            ST_START: state_next = ST_WAIT;
            ST_WAIT:  if (job_ending) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        Eng_Start_o = (state_reg == ST_START);
        Busy_o      = (state_reg != ST_IDLE);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            pending_reg    <= '0;
            sel_reg        <= '0;
            last_grant_reg <= LAST_RST;
            done_reg       <= '0;
        end else begin
            pending_reg <= pending_next;
            done_reg    <= done_next;
            if (grant_now) begin
                sel_reg <= grant_idx;
            end
            if (fire_done || fire_tmo) begin
                last_grant_reg <= sel_reg;
            end
        end
    end

`ifdef CMD_SCHEDULER_TIMEOUT_EN
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

    logic [15:0]     wd_cnt_reg, wd_cnt_next;
    logic [NREQ-1:0] timeout_reg, timeout_next;
    logic            wd_hit;

    // Counter holds the number of completed WAIT cycles; hit on the TIMEOUT-th one.
    assign wd_hit       = (state_reg == ST_WAIT) && (wd_cnt_reg == WD_LAST);
    assign wd_cnt_next  = (state_reg == ST_WAIT) ? (wd_cnt_reg + 16'd1) : '0;
    assign fire_tmo     = wd_hit && !job_ending && !Eng_Done_i;
    assign timeout_next = fire_tmo ? (NREQ'(1) << sel_reg) : '0;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wd_cnt_reg  <= '0;
            timeout_reg <= '0;
        end else begin
            wd_cnt_reg  <= wd_cnt_next;
            timeout_reg <= timeout_next;
        end
    end

    assign Timeout_o = timeout_reg;
`else
    assign fire_tmo  = 1'b0;
    assign Timeout_o = '0;
`endif

    assign Eng_Sel_o = sel_reg;
    assign Pending_o = pending_reg;
    assign Done_o    = done_reg;

endmodule

// File: tb/tb_cmd_scheduler.sv
// Self-checking bench for cmd_scheduler: vector table, directed corner sequences,
// and a randomized run against a job-timeline reference model.
module tb_cmd_scheduler;
    localparam int N   = 4;
    localparam int TMO = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] req;
    logic         en;
    logic         eng_done;
    logic         start;
    logic [1:0]   sel;
    logic [N-1:0] pend;
    logic         busy;
    logic [N-1:0] done;
    logic [N-1:0] tmo;

    always #5 clk = ~clk;

    cmd_scheduler #(.NREQ(N), .TIMEOUT(TMO)) dut (
        .Clk(clk), .Rst_n(rst_n), .Req_i(req), .Enable_i(en),
        .Eng_Start_o(start), .Eng_Sel_o(sel), .Eng_Done_i(eng_done),
        .Pending_o(pend), .Busy_o(busy), .Done_o(done), .Timeout_o(tmo)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: a job is described by its grant cycle and end cycle.
    bit [N-1:0] m_pend;
    int         m_last, m_owner, m_gcyc, m_end;
    bit         m_act, m_to;

    int grant_q[$];
    int done_q[$];
    int tmo_cnt;

    typedef struct {
        logic [N-1:0] req;
        logic         en;
        logic         dn;
        logic         st;
        logic [1:0]   sel;
        logic         bsy;
        logic [N-1:0] pnd;
        logic [N-1:0] dne;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pend  = '0;
        m_last  = N - 1;
        m_owner = 0;
        m_gcyc  = -1000;
        m_end   = -1;
        m_act   = 1'b0;
        m_to    = 1'b0;
    endtask

    task automatic model_step(input logic [N-1:0] r, input logic e, input logic d);
        bit idle_now;
        int g;
        idle_now = !m_act;
        if (m_act && cyc == m_end) begin
            m_act = 1'b0;
        end else if (m_act && cyc >= m_gcyc + 2 && m_end < 0) begin
            if (d) begin
                m_end  = cyc + 1;
                m_to   = 1'b0;
                m_last = m_owner;
            end
`ifdef CMD_SCHEDULER_TIMEOUT_EN
            else if (cyc - m_gcyc - 1 == TMO) begin
                m_end  = cyc + 1;
                m_to   = 1'b1;
                m_last = m_owner;
            end
`endif
        end
        if (idle_now && e && m_pend != 0) begin
            g = -1;
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (g < 0 && m_pend[c]) g = c;
            end
            m_act     = 1'b1;
            m_gcyc    = cyc;
            m_owner   = g;
            m_end     = -1;
            m_pend[g] = 1'b0;
        end
        m_pend = m_pend | r;
        cyc++;
    endtask

    // One clock cycle: drive inputs, compare every output with the model, advance.
    task automatic cycle(input logic [N-1:0] r, input logic e, input logic d);
        logic [N-1:0] e_done, e_tmo;
        @(posedge clk);
        #1;
        req = r; en = e; eng_done = d;
        e_done = '0;
        e_tmo  = '0;
        if (m_act && cyc == m_end) begin
            if (m_to) e_tmo[m_owner] = 1'b1;
            else      e_done[m_owner] = 1'b1;
        end
        chk("start", start, (m_act && cyc == m_gcyc + 1));
        chk("sel",   sel,   m_owner);
        chk("busy",  busy,  (m_act && cyc > m_gcyc));
        chk("pend",  pend,  m_pend);
        chk("done",  done,  e_done);
        chk("tmo",   tmo,   e_tmo);
        if (start) grant_q.push_back(int'(sel));
        for (int i = 0; i < N; i++) begin
            if (done[i]) begin
                done_q.push_back(i);
                $display("cyc=%0d job done requester=%0d", cyc, i);
            end
            if (tmo[i]) begin
                tmo_cnt++;
                $display("cyc=%0d job timeout requester=%0d", cyc, i);
            end
        end
        model_step(r, e, d);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = '0; en = 1'b1; eng_done = 1'b0;
        model_reset();
        grant_q.delete();
        done_q.delete();
        tmo_cnt = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic add_vec(input logic [N-1:0] r, input logic e, input logic d, input logic st,
                           input logic [1:0] s, input logic b, input logic [N-1:0] p, input logic [N-1:0] dn);
        vec_t v;
        v.req = r; v.en = e; v.dn = d; v.st = st; v.sel = s; v.bsy = b; v.pnd = p; v.dne = dn;
        vecs.push_back(v);
    endtask

    initial begin
        #1ms;
        $display("FAIL global_timeout cyc=%0d got=running want=finished", cyc);
        $fatal(1, "bench time limit");
    end

    initial begin
        int last_start;
        int probe;
        bit repulsed;
        logic [N-1:0] r;
        int first_sel;
        int wait_n;

        //        req    en dn  st sel bsy pnd    dne
        add_vec(4'b0001, 1, 0,  0, 0,  0, 4'b0000, 4'b0000);
        add_vec(4'b0000, 1, 0,  0, 0,  0, 4'b0001, 4'b0000);
        add_vec(4'b0000, 1, 0,  1, 0,  1, 4'b0000, 4'b0000);
        add_vec(4'b0000, 1, 1,  0, 0,  1, 4'b0000, 4'b0000);
        add_vec(4'b0010, 1, 0,  0, 0,  1, 4'b0000, 4'b0001);
        add_vec(4'b0000, 1, 0,  0, 0,  0, 4'b0010, 4'b0000);
        add_vec(4'b0000, 1, 0,  1, 1,  1, 4'b0000, 4'b0000);
        add_vec(4'b0000, 1, 1,  0, 1,  1, 4'b0000, 4'b0000);
        add_vec(4'b0000, 1, 0,  0, 1,  1, 4'b0000, 4'b0010);
        add_vec(4'b0000, 1, 1,  0, 1,  0, 4'b0000, 4'b0000);
        add_vec(4'b0100, 1, 0,  0, 1,  0, 4'b0000, 4'b0000);
        add_vec(4'b0100, 1, 0,  0, 1,  0, 4'b0100, 4'b0000);
        add_vec(4'b0000, 1, 1,  1, 2,  1, 4'b0100, 4'b0000);
        add_vec(4'b0000, 1, 0,  0, 2,  1, 4'b0100, 4'b0000);
        add_vec(4'b0000, 1, 1,  0, 2,  1, 4'b0100, 4'b0000);
        add_vec(4'b0000, 1, 0,  0, 2,  1, 4'b0100, 4'b0100);
        add_vec(4'b0000, 1, 0,  0, 2,  0, 4'b0100, 4'b0000);
        add_vec(4'b0000, 1, 0,  1, 2,  1, 4'b0000, 4'b0000);
        add_vec(4'b0000, 1, 1,  0, 2,  1, 4'b0000, 4'b0000);
        add_vec(4'b0000, 1, 0,  0, 2,  1, 4'b0000, 4'b0100);
        add_vec(4'b0000, 1, 0,  0, 2,  0, 4'b0000, 4'b0000);

        rst_n = 1'b0; req = '0; en = 1'b1; eng_done = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_start", start, 0);
        do_reset();

        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i].req, vecs[i].en, vecs[i].dn);
            chk("vec_start", start, vecs[i].st);
            chk("vec_sel",   sel,   vecs[i].sel);
            chk("vec_busy",  busy,  vecs[i].bsy);
            chk("vec_pend",  pend,  vecs[i].pnd);
            chk("vec_done",  done,  vecs[i].dne);
        end

        // Round-robin over all four, engine finishing 3 cycles after each start.
        do_reset();
        cycle(4'b1111, 1'b1, 1'b0);
        last_start = -1000;
        for (int k = 0; k < 80 && done_q.size() < 4; k++) begin
            cycle('0, 1'b1, cyc == last_start + 3);
            if (start) last_start = cyc - 1;
        end
        chk("rr_grants", grant_q.size(), 4);
        chk("rr_dones",  done_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk("rr_grant_order", (i < grant_q.size()) ? grant_q[i] : -1, i);
            chk("rr_done_order",  (i < done_q.size())  ? done_q[i]  : -1, i);
        end

        // Re-request of requester 1 while it is being serviced.
        do_reset();
        cycle(4'b0110, 1'b1, 1'b0);
        last_start = -1000;
        probe = -1;
        repulsed = 1'b0;
        for (int k = 0; k < 80 && done_q.size() < 3; k++) begin
            r = '0;
            if (grant_q.size() == 1 && cyc == last_start + 1 && !repulsed) begin
                r = 4'b0010;
                repulsed = 1'b1;
                probe = cyc + 1;
            end
            cycle(r, 1'b1, cyc == last_start + 3);
            if (start) last_start = cyc - 1;
            if (cyc - 1 == probe) chk("rereq_pend1", pend[1], 1);
        end
        chk("rereq_count", grant_q.size(), 3);
        chk("rereq_g0", (grant_q.size() > 0) ? grant_q[0] : -1, 1);
        chk("rereq_g1", (grant_q.size() > 1) ? grant_q[1] : -1, 2);
        chk("rereq_g2", (grant_q.size() > 2) ? grant_q[2] : -1, 1);

        // Enable gating with two requests pending.
        do_reset();
        cycle(4'b0110, 1'b0, 1'b0);
        for (int k = 0; k < 50; k++) cycle('0, 1'b0, 1'b0);
        chk("gate_nostart", grant_q.size(), 0);
        chk("gate_pend", pend, 4'b0110);
        wait_n = 0;
        for (int k = 0; k < 4 && grant_q.size() == 0; k++) begin
            cycle('0, 1'b1, 1'b0);
            wait_n++;
        end
        first_sel = (grant_q.size() > 0) ? grant_q[0] : -1;
        chk("gate_sel", first_sel, 1);
        chk("gate_latency_ok", (wait_n >= 1 && wait_n <= 2), 1);

        // Engine never answers.
        do_reset();
        cycle(4'b0001, 1'b1, 1'b0);
        for (int k = 0; k < 30; k++) cycle('0, 1'b1, 1'b0);
`ifdef CMD_SCHEDULER_TIMEOUT_EN
        chk("to_pulses", tmo_cnt, 1);
        chk("to_nodone", done_q.size(), 0);
        chk("to_busy", busy, 0);

        // Engine answers exactly on the limit cycle: done wins.
        do_reset();
        cycle(4'b0001, 1'b1, 1'b0);
        last_start = -1000;
        for (int k = 0; k < 40; k++) begin
            cycle('0, 1'b1, cyc == last_start + TMO);
            if (start) last_start = cyc - 1;
        end
        chk("lim_done", done_q.size(), 1);
        chk("lim_notmo", tmo_cnt, 0);
`else
        chk("to_pulses", tmo_cnt, 0);
        chk("to_busy", busy, 1);
`endif

        // Asynchronous reset while the job waits on the engine.
        do_reset();
        cycle(4'b0001, 1'b1, 1'b0);
        cycle('0, 1'b1, 1'b0);
        cycle('0, 1'b1, 1'b0);
        cycle(4'b0100, 1'b1, 1'b0);
        cycle('0, 1'b1, 1'b0);
        chk("ar_busy_before", busy, 1);
        #3 rst_n = 1'b0;
        #1;
        chk("ar_start", start, 0);
        chk("ar_sel", sel, 0);
        chk("ar_busy", busy, 0);
        chk("ar_pend", pend, 0);
        chk("ar_done", done, 0);
        chk("ar_tmo", tmo, 0);
        req = '0; eng_done = 1'b0;
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cycle('0, 1'b1, k == 0);
            chk("ar_nodone", done, 0);
        end

        // Randomized traffic against the model.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            r = ($urandom_range(0, 9) == 0) ? N'($urandom) : '0;
            cycle(r, $urandom_range(0, 7) != 0, $urandom_range(0, 4) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
